// File: rtl/count_capture_if.sv
// Bundle of the control, sample and read-port signals of the capture buffer.
//
// Read handshake: rd_valid/rd_ready follow strict valid/ready semantics. An
// entry transfers on a rising clk edge where rd_valid && rd_ready. While
// rd_valid is high and rd_ready is low, rd_data and rd_valid hold stable.
// rd_ready is ignored while rd_valid is low. in_valid has no back-pressure:
// a sample is offered for exactly the cycle in_valid is high.
interface count_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              arm;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   fill_level;

  // Host / stimulus side.
  modport master (
    output arm, abort, in_valid, in_data, rd_ready,
    input  rd_valid, rd_data, busy, done, fill_level
  );

  // Capture buffer side.
  modport slave (
    input  arm, abort, in_valid, in_data, rd_ready,
    output rd_valid, rd_data, busy, done, fill_level
  );
endinterface

// File: rtl/count_capture_buf.sv
// Triggered capture buffer: once armed, waits for the counter sample equal to
// TRIG_VALUE, stores DEPTH consecutive valid samples starting with it, then
// drains them through a first-word fall-through valid/ready read port.
module count_capture_buf #(
  parameter int          DATA_W     = 8,
  parameter int          ADDR_W     = 4,
  parameter int unsigned TRIG_VALUE = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  count_capture_if.slave      bus,
  output logic [1:0]          state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FILL_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] TRIG      = DATA_W'(TRIG_VALUE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state logic; abort overrides every other action in the same cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    if (bus.abort) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arm) begin
            state_d  = ST_ARMED;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
          end
        end
        ST_ARMED: begin
          // The trigger sample itself is the first stored entry.
          if (bus.in_valid && (bus.in_data == TRIG)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            fill_d   = fill_q + (ADDR_W + 1)'(1);
            state_d  = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Trigger is not re-checked here; gaps simply hold the state.
          if (bus.in_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            fill_d   = fill_q + (ADDR_W + 1)'(1);
            if (fill_q == FILL_LAST) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.rd_ready) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            fill_d   = fill_q - (ADDR_W + 1)'(1);
            if (fill_q == (ADDR_W + 1)'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, pointer, fill and done registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      done_q   <= done_d;
    end
  end

  // Sample storage; contents are don't-care after reset so no clear.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  // Outputs: rd_data is zero outside DRAIN so it reads 0 under reset.
  always_comb begin
    bus.rd_valid   = (state_q == ST_DRAIN);
    bus.rd_data    = (state_q == ST_DRAIN) ? mem[rd_ptr_q] : '0;
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = done_q;
    bus.fill_level = fill_q;
    state_dbg      = state_q;
  end

endmodule
